// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/mult-div control bundle between pipeline and pipe_ctrl
interface pipe_ctrl_if;
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic [1:0]  TUse_rs;
    logic [1:0]  TUse_rt;
    logic [4:0]  WR_E;
    logic [4:0]  WR_M;
    logic        RegWrite_E;
    logic        RegWrite_M;
    logic [1:0]  TNew_E;
    logic [1:0]  TNew_M;
    logic        md_start_E;
    logic        md_div_E;
    logic        md_use_D;
    logic        req;
    logic        stall;
    logic        flush_E;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output rs_D, rt_D, TUse_rs, TUse_rt, WR_E, WR_M,
        output RegWrite_E, RegWrite_M, TNew_E, TNew_M,
        output md_start_E, md_div_E, md_use_D, req,
        input  stall, flush_E, md_busy, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, TUse_rs, TUse_rt, WR_E, WR_M,
        input  RegWrite_E, RegWrite_M, TNew_E, TNew_M,
        input  md_start_E, md_div_E, md_use_D, req,
        output stall, flush_E, md_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - data/mult-div hazard stall generation and mult/div busy tracking
module pipe_ctrl (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_BUSY     = 1'b1;
    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    logic [0:0]  r_state;
    logic [3:0]  r_md_cnt;
    logic        r_md_busy;
    logic [31:0] r_stall_cnt;

    logic w_rs_e;
    logic w_rs_m;
    logic w_rt_e;
    logic w_rt_m;
    logic w_data_stall;
    logic w_md_stall;
    logic w_stall;
    logic w_md_accept;

    // Register 0 never carries a real dependency, so it is excluded up front.
    assign w_rs_e = (bus.rs_D != 5'd0) && bus.RegWrite_E &&
                    (bus.WR_E == bus.rs_D) && (bus.TNew_E > bus.TUse_rs);
    assign w_rs_m = (bus.rs_D != 5'd0) && bus.RegWrite_M &&
                    (bus.WR_M == bus.rs_D) && (bus.TNew_M > bus.TUse_rs);
    assign w_rt_e = (bus.rt_D != 5'd0) && bus.RegWrite_E &&
                    (bus.WR_E == bus.rt_D) && (bus.TNew_E > bus.TUse_rt);
    assign w_rt_m = (bus.rt_D != 5'd0) && bus.RegWrite_M &&
                    (bus.WR_M == bus.rt_D) && (bus.TNew_M > bus.TUse_rt);

    assign w_data_stall = w_rs_e | w_rs_m | w_rt_e | w_rt_m;
    assign w_md_stall   = bus.md_use_D & (r_md_busy | bus.md_start_E);

    // A pending exception squashes D, so holding it would only delay the trap.
    assign w_stall     = (w_data_stall | w_md_stall) & ~bus.req;
    assign w_md_accept = bus.md_start_E & ~bus.req;

    assign bus.stall     = w_stall;
    assign bus.flush_E   = w_stall;
    assign bus.md_busy   = r_md_busy;
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_md_cnt  <= 4'd0;
            r_md_busy <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_md_accept) begin
                r_md_cnt  <= bus.md_div_E ? DIV_CYCLES : MUL_CYCLES;
                r_state   <= S_BUSY;
                r_md_busy <= 1'b1;
            end
        end else begin
            // Once started, the unit runs to completion regardless of req or new starts.
            if (r_md_cnt == 4'd1) begin
                r_md_cnt  <= 4'd0;
                r_state   <= S_IDLE;
                r_md_busy <= 1'b0;
            end else begin
                r_md_cnt <= r_md_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.rs_D       = 5'd0;
        bus.rt_D       = 5'd0;
        bus.TUse_rs    = 2'd3;
        bus.TUse_rt    = 2'd3;
        bus.WR_E       = 5'd0;
        bus.WR_M       = 5'd0;
        bus.RegWrite_E = 1'b0;
        bus.RegWrite_M = 1'b0;
        bus.TNew_E     = 2'd0;
        bus.TNew_M     = 2'd0;
        bus.md_start_E = 1'b0;
        bus.md_div_E   = 1'b0;
        bus.md_use_D   = 1'b0;
        bus.req        = 1'b0;
    endtask

    task automatic load_use();
        bus.RegWrite_E = 1'b1;
        bus.WR_E       = 5'd5;
        bus.TNew_E     = 2'd2;
        bus.rs_D       = 5'd5;
        bus.TUse_rs    = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        clr();
        #1;
        check("rst_md_busy", {31'd0, bus.md_busy}, 32'd0);
        check("rst_stall_cnt", bus.stall_cnt, 32'd0);
        check("rst_stall_idle", {31'd0, bus.stall}, 32'd0);
        load_use();
        #1;
        check("rst_stall_comb", {31'd0, bus.stall}, 32'd1);
        check("rst_flush_comb", {31'd0, bus.flush_E}, 32'd1);
        step();
        check("rst_cnt_held", bus.stall_cnt, 32'd0);
        clr();
        reset = 1'b1;
        #1;
        check("idle_stall", {31'd0, bus.stall}, 32'd0);

        // load-use through E on rs
        load_use();
        #1;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        check("lu_flush", {31'd0, bus.flush_E}, 32'd1);
        step();
        check("lu_cnt", bus.stall_cnt, 32'd1);
        bus.TNew_E  = 2'd1;
        bus.TUse_rs = 2'd1;
        #1;
        check("lu_ready", {31'd0, bus.stall}, 32'd0);
        step();
        check("lu_cnt_hold", bus.stall_cnt, 32'd1);

        // M-stage dependency on rt
        clr();
        bus.RegWrite_M = 1'b1;
        bus.WR_M       = 5'd7;
        bus.TNew_M     = 2'd1;
        bus.rt_D       = 5'd7;
        bus.TUse_rt    = 2'd0;
        #1;
        check("m_rt_stall", {31'd0, bus.stall}, 32'd1);
        step();
        check("m_rt_cnt", bus.stall_cnt, 32'd2);
        bus.TUse_rt = 2'd3;
        #1;
        check("m_rt_unused", {31'd0, bus.stall}, 32'd0);
        bus.TUse_rt    = 2'd0;
        bus.RegWrite_M = 1'b0;
        #1;
        check("m_rt_nowrite", {31'd0, bus.stall}, 32'd0);

        // register zero and mismatched destination
        clr();
        bus.RegWrite_E = 1'b1;
        bus.TNew_E     = 2'd2;
        bus.TUse_rs    = 2'd0;
        bus.TUse_rt    = 2'd0;
        #1;
        check("r0_neutral", {31'd0, bus.stall}, 32'd0);
        bus.WR_E = 5'd6;
        bus.rs_D = 5'd5;
        #1;
        check("wr_mismatch", {31'd0, bus.stall}, 32'd0);

        // exception priority
        clr();
        load_use();
        bus.req = 1'b1;
        #1;
        check("req_kills_stall", {31'd0, bus.stall}, 32'd0);
        clr();
        bus.md_start_E = 1'b1;
        bus.req        = 1'b1;
        step();
        clr();
        #1;
        check("req_squash_md", {31'd0, bus.md_busy}, 32'd0);
        check("req_cnt_hold", bus.stall_cnt, 32'd2);

        // divide with dependent md instruction in D
        bus.md_start_E = 1'b1;
        bus.md_div_E   = 1'b1;
        bus.md_use_D   = 1'b1;
        #1;
        check("div_start_stall", {31'd0, bus.stall}, 32'd1);
        step();
        bus.md_start_E = 1'b0;
        bus.md_div_E   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("div_busy_%0d", i), {31'd0, bus.md_busy}, 32'd1);
            check($sformatf("div_stall_%0d", i), {31'd0, bus.stall}, 32'd1);
            step();
        end
        #1;
        check("div_done", {31'd0, bus.md_busy}, 32'd0);
        check("div_unstall", {31'd0, bus.stall}, 32'd0);
        check("div_cnt", bus.stall_cnt, 32'd13);
        clr();

        // multiply with req pulse at md_cnt=3 and ignored start while busy
        bus.md_start_E = 1'b1;
        step();
        bus.md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.req        = (i == 2);
            bus.md_start_E = (i == 1);
            bus.md_div_E   = (i == 1);
            #1;
            check($sformatf("mul_busy_%0d", i), {31'd0, bus.md_busy}, 32'd1);
            step();
        end
        clr();
        #1;
        check("mul_done", {31'd0, bus.md_busy}, 32'd0);
        step();
        check("mul_no_restart", {31'd0, bus.md_busy}, 32'd0);
        check("mul_cnt", bus.stall_cnt, 32'd13);

        // asynchronous reset mid-multiply, then immediate restart
        bus.md_start_E = 1'b1;
        step();
        bus.md_start_E = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.md_busy}, 32'd0);
        check("arst_cnt", bus.stall_cnt, 32'd0);
        load_use();
        #1;
        check("arst_stall_comb", {31'd0, bus.stall}, 32'd1);
        clr();
        @(negedge clk);
        reset = 1'b1;
        bus.md_start_E = 1'b1;
        step();
        bus.md_start_E = 1'b0;
        check("rel_busy_0", {31'd0, bus.md_busy}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("rel_busy_%0d", i), {31'd0, bus.md_busy}, 32'd1);
        end
        step();
        check("rel_done", {31'd0, bus.md_busy}, 32'd0);
        check("rel_cnt", bus.stall_cnt, 32'd0);

        // saturation of the stall counter
        load_use();
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cnt;
        #1;
        check("sat_preset", bus.stall_cnt, 32'hFFFF_FFFD);
        step();
        check("sat_fe", bus.stall_cnt, 32'hFFFF_FFFE);
        step();
        check("sat_ff", bus.stall_cnt, 32'hFFFF_FFFF);
        step();
        step();
        check("sat_hold", bus.stall_cnt, 32'hFFFF_FFFF);
        clr();
        step();
        check("sat_idle", bus.stall_cnt, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
